// File: rtl/seq_pkg.sv
// Shared types and encodings for the ALU instruction sequencer: FSM states,
// opcode and ALU CONTROL encodings, and IR field positions.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_e;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SHL = 5'b01000;
    localparam logic [4:0] OP_ROR = 5'b01001;
    localparam logic [4:0] OP_ROL = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    localparam logic [4:0] CTL_ADD = 5'b00000;
    localparam logic [4:0] CTL_SUB = 5'b00001;
    localparam logic [4:0] CTL_AND = 5'b00010;
    localparam logic [4:0] CTL_OR  = 5'b00011;
    localparam logic [4:0] CTL_SHR = 5'b00100;
    localparam logic [4:0] CTL_SHL = 5'b00101;
    localparam logic [4:0] CTL_ROR = 5'b00110;
    localparam logic [4:0] CTL_ROL = 5'b00111;
    localparam logic [4:0] CTL_MUL = 5'b01000;
    localparam logic [4:0] CTL_DIV = 5'b01001;
    localparam logic [4:0] CTL_NEG = 5'b01010;
    localparam logic [4:0] CTL_NOT = 5'b01011;

    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;
    localparam int RFLD_W  = 4;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: legality, ALU CONTROL code, unary flag and
// multiply/divide flag. MUL/DIV are only legal when MULDIV_EN is defined.
module alu_op_decode
    import seq_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int CTRL_W   = 5
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                legal_o,
    output logic [CTRL_W-1:0]   control_o,
    output logic                unary_o,
    output logic                muldiv_o
);

    always_comb begin
        legal_o   = 1'b1;
        control_o = '0;
        unary_o   = 1'b0;
        muldiv_o  = 1'b0;
        case (opcode_i)
            OP_ADD: control_o = CTRL_W'(CTL_ADD);
            OP_SUB: control_o = CTRL_W'(CTL_SUB);
            OP_AND: control_o = CTRL_W'(CTL_AND);
            OP_OR:  control_o = CTRL_W'(CTL_OR);
            OP_SHR: control_o = CTRL_W'(CTL_SHR);
            OP_SHL: control_o = CTRL_W'(CTL_SHL);
            OP_ROR: control_o = CTRL_W'(CTL_ROR);
            OP_ROL: control_o = CTRL_W'(CTL_ROL);
            OP_NEG: begin
                control_o = CTRL_W'(CTL_NEG);
                unary_o   = 1'b1;
            end
            OP_NOT: begin
                control_o = CTRL_W'(CTL_NOT);
                unary_o   = 1'b1;
            end
`ifdef MULDIV_EN
            OP_MUL: begin
                control_o = CTRL_W'(CTL_MUL);
                muldiv_o  = 1'b1;
            end
            OP_DIV: begin
                control_o = CTRL_W'(CTL_DIV);
                muldiv_o  = 1'b1;
            end
`endif
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control FSM running one register-to-register ALU instruction through
// the bus Datapath (fetch T0-T2, execute T3-T5). MULDIV_EN adds MUL/DIV with T6.
module alu_instr_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPCODE_W = 5,
    parameter int CTRL_W   = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Start,
    input  logic                Mem_Ready,
    input  logic [31:0]         IR_Value,
    output logic                PC_Out,
    output logic                MDR_Out,
    output logic                ZLO_Out,
    output logic                PC_In,
    output logic                MAR_In,
    output logic                MDR_In,
    output logic                IR_In,
    output logic                Y_In,
    output logic                ZLO_In,
    output logic                Read,
    output logic                IncPC,
    output logic [CTRL_W-1:0]   CONTROL,
    output logic [NUM_REGS-1:0] R_Out,
    output logic [NUM_REGS-1:0] R_In,
`ifdef MULDIV_EN
    output logic                ZHI_Out,
    output logic                HI_In,
    output logic                LO_In,
`endif
    output logic                Busy,
    output logic                Done,
    output logic                Illegal
);

    state_e state_q, state_d;
    logic   pc_loaded_q;

    logic [RFLD_W-1:0] ra, rb, rc;
    logic              op_legal, op_unary, op_muldiv;
    logic [CTRL_W-1:0] op_ctrl;
    logic              unused_ir;

    assign ra        = IR_Value[RA_MSB -: RFLD_W];
    assign rb        = IR_Value[RB_MSB -: RFLD_W];
    assign rc        = IR_Value[RC_MSB -: RFLD_W];
    assign unused_ir = ^IR_Value[RC_MSB-RFLD_W:0];

    alu_op_decode #(
        .OPCODE_W (OPCODE_W),
        .CTRL_W   (CTRL_W)
    ) u_dec (
        .opcode_i  (IR_Value[OPC_MSB -: OPCODE_W]),
        .legal_o   (op_legal),
        .control_o (op_ctrl),
        .unary_o   (op_unary),
        .muldiv_o  (op_muldiv)
    );

`ifndef MULDIV_EN
    logic unused_muldiv;
    assign unused_muldiv = op_muldiv;
`endif

    // pc_loaded_q is set once the first T1 cycle has passed, so a memory
    // stall does not reload PC from Z on every waiting cycle.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q     <= IDLE;
            pc_loaded_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_loaded_q <= (state_q == T1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Start) state_d = T0;
            T0:   state_d = T1;
            T1:   if (Mem_Ready) state_d = T2;
            T2:   state_d = T3;
            T3:   state_d = op_legal ? T4 : IDLE;
            T4:   state_d = T5;
`ifdef MULDIV_EN
            T5:   state_d = op_muldiv ? T6 : (Start ? T0 : IDLE);
            T6:   state_d = Start ? T0 : IDLE;
`else
            T5:   state_d = Start ? T0 : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        PC_In   = 1'b0;
        MAR_In  = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        Read    = 1'b0;
        IncPC   = 1'b0;
        CONTROL = '0;
        R_Out   = '0;
        R_In    = '0;
`ifdef MULDIV_EN
        ZHI_Out = 1'b0;
        HI_In   = 1'b0;
        LO_In   = 1'b0;
`endif
        Busy    = (state_q != IDLE);
        Done    = 1'b0;
        Illegal = 1'b0;
        case (state_q)
            T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                ZLO_In = 1'b1;
            end
            T1: begin
                ZLO_Out = 1'b1;
                PC_In   = ~pc_loaded_q;
                Read    = 1'b1;
                MDR_In  = 1'b1;
            end
            T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            T3: begin
                if (op_legal) begin
                    R_Out = NUM_REGS'(1) << rb;
                    Y_In  = 1'b1;
                end else begin
                    Illegal = 1'b1;
                end
            end
            T4: begin
                R_Out   = NUM_REGS'(1) << (op_unary ? rb : rc);
                CONTROL = op_ctrl;
                ZLO_In  = 1'b1;
            end
            T5: begin
                ZLO_Out = 1'b1;
`ifdef MULDIV_EN
                if (op_muldiv) begin
                    LO_In = 1'b1;
                end else begin
                    R_In = NUM_REGS'(1) << ra;
                    Done = 1'b1;
                end
`else
                R_In = NUM_REGS'(1) << ra;
                Done = 1'b1;
`endif
            end
`ifdef MULDIV_EN
            T6: begin
                ZHI_Out = 1'b1;
                HI_In   = 1'b1;
                Done    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: per-cycle expected output vectors
// are queued with their stimulus and compared after each rising edge.
module tb_alu_instr_sequencer;

    logic        Clock = 1'b0;
    logic        Clear, Start, Mem_Ready;
    logic [31:0] IR_Value;
    logic        PC_Out, MDR_Out, ZLO_Out, PC_In, MAR_In, MDR_In, IR_In;
    logic        Y_In, ZLO_In, Read, IncPC, Busy, Done, Illegal;
    logic [4:0]  CONTROL;
    logic [15:0] R_Out, R_In;
`ifdef MULDIV_EN
    logic        ZHI_Out, HI_In, LO_In;
`endif

    always #5 Clock = ~Clock;

    alu_instr_sequencer dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Start     (Start),
        .Mem_Ready (Mem_Ready),
        .IR_Value  (IR_Value),
        .PC_Out    (PC_Out),
        .MDR_Out   (MDR_Out),
        .ZLO_Out   (ZLO_Out),
        .PC_In     (PC_In),
        .MAR_In    (MAR_In),
        .MDR_In    (MDR_In),
        .IR_In     (IR_In),
        .Y_In      (Y_In),
        .ZLO_In    (ZLO_In),
        .Read      (Read),
        .IncPC     (IncPC),
        .CONTROL   (CONTROL),
        .R_Out     (R_Out),
        .R_In      (R_In),
`ifdef MULDIV_EN
        .ZHI_Out   (ZHI_Out),
        .HI_In     (HI_In),
        .LO_In     (LO_In),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Illegal   (Illegal)
    );

    typedef struct packed {
        logic        busy, done, ill;
        logic        pco, mdro, zlo;
        logic        pci, mari, mdri, iri, yi, zli, rd, inc;
        logic [4:0]  ctrl;
        logic [15:0] ro, ri;
`ifdef MULDIV_EN
        logic        zho, hii, loi;
`endif
    } ov_t;

    typedef struct {
        logic        st, rdy, clr;
        logic [31:0] ir;
        ov_t         exp;
    } ent_t;

    ent_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ov_t cur();
        ov_t v;
        v = '0;
        v.busy = Busy;   v.done = Done;     v.ill = Illegal;
        v.pco  = PC_Out; v.mdro = MDR_Out;  v.zlo = ZLO_Out;
        v.pci  = PC_In;  v.mari = MAR_In;   v.mdri = MDR_In;  v.iri = IR_In;
        v.yi   = Y_In;   v.zli  = ZLO_In;   v.rd  = Read;     v.inc = IncPC;
        v.ctrl = CONTROL; v.ro = R_Out;     v.ri  = R_In;
`ifdef MULDIV_EN
        v.zho = ZHI_Out; v.hii = HI_In; v.loi = LO_In;
`endif
        return v;
    endfunction

    function automatic int bus_drivers();
        int n;
        n = int'(PC_Out) + int'(MDR_Out) + int'(ZLO_Out) + $countones(R_Out);
`ifdef MULDIV_EN
        n += int'(ZHI_Out);
`endif
        return n;
    endfunction

    function automatic ov_t e_t0();
        ov_t v = '0;
        v.busy = 1; v.pco = 1; v.mari = 1; v.inc = 1; v.zli = 1;
        return v;
    endfunction

    function automatic ov_t e_t1(input logic first);
        ov_t v = '0;
        v.busy = 1; v.zlo = 1; v.pci = first; v.rd = 1; v.mdri = 1;
        return v;
    endfunction

    function automatic ov_t e_t2();
        ov_t v = '0;
        v.busy = 1; v.mdro = 1; v.iri = 1;
        return v;
    endfunction

    function automatic ov_t e_t3(input int rb);
        ov_t v = '0;
        v.busy = 1; v.ro = 16'(1 << rb); v.yi = 1;
        return v;
    endfunction

    function automatic ov_t e_ill();
        ov_t v = '0;
        v.busy = 1; v.ill = 1;
        return v;
    endfunction

    function automatic ov_t e_t4(input int r, input logic [4:0] ctrl);
        ov_t v = '0;
        v.busy = 1; v.ro = 16'(1 << r); v.ctrl = ctrl; v.zli = 1;
        return v;
    endfunction

    function automatic ov_t e_t5(input int ra);
        ov_t v = '0;
        v.busy = 1; v.zlo = 1; v.ri = 16'(1 << ra); v.done = 1;
        return v;
    endfunction

    task automatic push(input logic st, input logic rdy, input logic clr,
                        input logic [31:0] ir, input ov_t e);
        ent_t x;
        x.st = st; x.rdy = rdy; x.clr = clr; x.ir = ir; x.exp = e;
        sbq.push_back(x);
    endtask

    // Queues one instruction starting from IDLE or T5; hold drives Start while busy.
    task automatic push_instr(input logic [4:0] op, input int ra, input int rb, input int rc,
                              input logic [4:0] ctrl, input logic legal, input logic unary,
                              input logic muldiv, input logic hold, input int stalls);
        logic [31:0] ir;
        ir = {op, 4'(ra), 4'(rb), 4'(rc), 15'h2A5C};
        push(1'b1, 1'b1, 1'b0, ir, e_t0());
        push(hold, 1'b1, 1'b0, ir, e_t1(1'b1));
        for (int i = 0; i < stalls; i++) push(hold, 1'b0, 1'b0, ir, e_t1(1'b0));
        push(hold, 1'b1, 1'b0, ir, e_t2());
        if (!legal) begin
            push(hold, 1'b1, 1'b0, ir, e_ill());
            return;
        end
        push(hold, 1'b1, 1'b0, ir, e_t3(rb));
        push(hold, 1'b1, 1'b0, ir, e_t4(unary ? rb : rc, ctrl));
`ifdef MULDIV_EN
        if (muldiv) begin
            ov_t v5, v6;
            v5 = '0; v5.busy = 1; v5.zlo = 1; v5.loi = 1;
            v6 = '0; v6.busy = 1; v6.zho = 1; v6.hii = 1; v6.done = 1;
            push(hold, 1'b1, 1'b0, ir, v5);
            push(hold, 1'b1, 1'b0, ir, v6);
            return;
        end
`endif
        if (!muldiv) push(hold, 1'b1, 1'b0, ir, e_t5(ra));
    endtask

    task automatic push_idle(input logic clr);
        push(1'b0, 1'b1, clr, 32'h0, ov_t'('0));
    endtask

    initial begin
        ent_t e;
        int   n;
        Clear = 1'b1; Start = 1'b0; Mem_Ready = 1'b1; IR_Value = 32'h0;

        // reset state
        push_idle(1'b1);
        push_idle(1'b1);
        push_idle(1'b0);

        // SUB Ra=5 Rb=2 Rc=4, Start held while busy (ignored)
        push_instr(5'b00100, 5, 2, 4, 5'b00001, 1, 0, 0, 1, 0);
        push_idle(1'b0);

        // memory stall of three cycles
        push_instr(5'b00011, 1, 3, 7, 5'b00000, 1, 0, 0, 0, 3);
        push_idle(1'b0);

        // unknown opcode
        push_instr(5'b11111, 1, 2, 3, 5'b00000, 0, 0, 0, 0, 0);
        push_idle(1'b0);

        // Clear in T4, then restart
        push(1'b1, 1'b1, 1'b0, {5'b00110, 4'd8, 4'd9, 4'd10, 15'h0}, e_t0());
        push(1'b0, 1'b1, 1'b0, {5'b00110, 4'd8, 4'd9, 4'd10, 15'h0}, e_t1(1'b1));
        push(1'b0, 1'b1, 1'b0, {5'b00110, 4'd8, 4'd9, 4'd10, 15'h0}, e_t2());
        push(1'b0, 1'b1, 1'b0, {5'b00110, 4'd8, 4'd9, 4'd10, 15'h0}, e_t3(9));
        push(1'b0, 1'b1, 1'b0, {5'b00110, 4'd8, 4'd9, 4'd10, 15'h0}, e_t4(10, 5'b00011));
        push(1'b0, 1'b1, 1'b1, {5'b00110, 4'd8, 4'd9, 4'd10, 15'h0}, ov_t'('0));
        push_instr(5'b00110, 8, 9, 10, 5'b00011, 1, 0, 0, 0, 0);
        push_idle(1'b0);

        // back-to-back ADDs with Start held
        push_instr(5'b00011, 14, 0, 15, 5'b00000, 1, 0, 0, 1, 0);
        push_instr(5'b00011, 13, 12, 11, 5'b00000, 1, 0, 0, 1, 0);
        push_idle(1'b0);

        // unary ops use Rb in T4; Ra==Rb==Rc
        push_instr(5'b10000, 6, 9, 12, 5'b01010, 1, 1, 0, 0, 0);
        push_idle(1'b0);
        push_instr(5'b10001, 0, 15, 1, 5'b01011, 1, 1, 0, 0, 1);
        push_idle(1'b0);
        push_instr(5'b00110, 3, 3, 3, 5'b00011, 1, 0, 0, 0, 0);
        push_idle(1'b0);
        push_instr(5'b01010, 4, 5, 6, 5'b00111, 1, 0, 0, 0, 0);
        push_idle(1'b0);
        push_instr(5'b00111, 2, 1, 0, 5'b00100, 1, 0, 0, 0, 0);
        push_idle(1'b0);

`ifdef MULDIV_EN
        push_instr(5'b01110, 7, 8, 9, 5'b01000, 1, 0, 1, 0, 0);
        push_idle(1'b0);
        push_instr(5'b01111, 7, 8, 9, 5'b01001, 1, 0, 1, 0, 0);
        push_idle(1'b0);
`else
        push_instr(5'b01110, 7, 8, 9, 5'b00000, 0, 0, 0, 0, 0);
        push_idle(1'b0);
`endif
        push_instr(5'b01011, 7, 8, 9, 5'b00000, 0, 0, 0, 0, 0);
        push_idle(1'b0);

        n = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            Start = e.st; Mem_Ready = e.rdy; Clear = e.clr; IR_Value = e.ir;
            @(posedge Clock);
            #1;
            chk($sformatf("cyc%0d", n), 64'(cur()), 64'(e.exp));
            chk($sformatf("bus%0d", n), 64'(bus_drivers() <= 1), 64'd1);
            n++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
